// File: rtl/if_id_hazard_ctrl_if.sv
// Bundle of the ID/EX hazard inputs and the IF-stage control/status outputs.
// The pipeline side drives hazard sources; the controller side drives the enables.
interface if_id_hazard_ctrl_if #(
    parameter int REG_W = 5,
    parameter int CNT_W = 16
) ();
    logic [REG_W-1:0] id_rs;
    logic [REG_W-1:0] id_rt;
    logic             ex_mem_read;
    logic [REG_W-1:0] ex_rt;
    logic             branch_taken;
    logic             imem_ready;
    logic             pc_write;
    logic             if_id_write;
    logic             if_flush;
    logic             id_ex_bubble;
    logic             timeout_err;
    logic [CNT_W-1:0] stall_cnt;
    logic [CNT_W-1:0] flush_cnt;

    modport master (
        output id_rs, id_rt, ex_mem_read, ex_rt, branch_taken, imem_ready,
        input  pc_write, if_id_write, if_flush, id_ex_bubble, timeout_err,
               stall_cnt, flush_cnt
    );

    modport slave (
        input  id_rs, id_rt, ex_mem_read, ex_rt, branch_taken, imem_ready,
        output pc_write, if_id_write, if_flush, id_ex_bubble, timeout_err,
               stall_cnt, flush_cnt
    );
endinterface

// File: rtl/if_id_hazard_ctrl.sv
// IF / IF-ID hazard controller: load-use stalls, taken-branch flushes, imem waits
// with a deferred flush and fetch timeout, plus saturating stall/flush counters.
module if_id_hazard_ctrl #(
    parameter int REG_W   = 5,
    parameter int WAIT_W  = 4,
    parameter int TIMEOUT = 15,
    parameter int CNT_W   = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    if_id_hazard_ctrl_if.slave    hz
);

    typedef enum logic [1:0] {
        RUN  = 2'd0,
        WAIT = 2'd1,
        ERR  = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0]  CNT_MAX  = {CNT_W{1'b1}};
    localparam logic [WAIT_W-1:0] WAIT_TOP = WAIT_W'(TIMEOUT);

    state_t            state, next_state;
    logic              flush_pend, next_pend;
    logic [WAIT_W-1:0] wait_cnt, next_wait;
    logic [CNT_W-1:0]  stall_q, flush_q;

    logic load_use;
    logic pc_write, if_id_write, if_flush, bubble, timeout_err;

    assign load_use = hz.ex_mem_read && (hz.ex_rt != '0) &&
                      ((hz.ex_rt == hz.id_rs) || (hz.ex_rt == hz.id_rt));

    // Mealy control; defaults are the safe "hold everything, inject a bubble" setting.
    always_comb begin
        pc_write    = 1'b0;
        if_id_write = 1'b0;
        if_flush    = 1'b0;
        bubble      = 1'b1;
        timeout_err = 1'b0;
        next_state  = state;
        next_pend   = flush_pend;
        next_wait   = wait_cnt;
        if (rst_n) begin
            case (state)
                RUN: begin
                    if (hz.branch_taken) begin
                        pc_write = 1'b1;
                        if_flush = 1'b1;
                        bubble   = 1'b0;
                        if (!hz.imem_ready) begin
                            next_pend  = 1'b1;
                            next_state = WAIT;
                            next_wait  = WAIT_W'(1);
                        end
                    end else if (load_use) begin
                        next_state = RUN;
                    end else if (!hz.imem_ready) begin
                        next_state = WAIT;
                        next_wait  = WAIT_W'(1);
                    end else begin
                        pc_write    = 1'b1;
                        if_id_write = 1'b1;
                        bubble      = 1'b0;
                    end
                end
                WAIT: begin
                    if (!hz.imem_ready) begin
                        if (wait_cnt == WAIT_TOP) begin
                            next_state = ERR;
                        end else begin
                            next_wait = wait_cnt + WAIT_W'(1);
                        end
                    end else if (flush_pend) begin
                        // The word arriving now belongs to the old path; drop it.
                        pc_write   = 1'b1;
                        if_flush   = 1'b1;
                        next_pend  = 1'b0;
                        next_wait  = '0;
                        next_state = RUN;
                    end else begin
                        pc_write    = 1'b1;
                        if_id_write = 1'b1;
                        bubble      = 1'b0;
                        next_wait   = '0;
                        next_state  = RUN;
                    end
                end
                ERR: begin
                    timeout_err = 1'b1;
                end
                default: begin
                    next_state = RUN;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= RUN;
            flush_pend <= 1'b0;
            wait_cnt   <= '0;
            stall_q    <= '0;
            flush_q    <= '0;
        end else begin
            state      <= next_state;
            flush_pend <= next_pend;
            wait_cnt   <= next_wait;
            if ((state != ERR) && !pc_write && (stall_q != CNT_MAX)) begin
                stall_q <= stall_q + CNT_W'(1);
            end
            if (if_flush && (flush_q != CNT_MAX)) begin
                flush_q <= flush_q + CNT_W'(1);
            end
        end
    end

    assign hz.pc_write     = pc_write;
    assign hz.if_id_write  = if_id_write;
    assign hz.if_flush     = if_flush;
    assign hz.id_ex_bubble = bubble;
    assign hz.timeout_err  = timeout_err;
    assign hz.stall_cnt    = stall_q;
    assign hz.flush_cnt    = flush_q;

endmodule

// File: tb/tb_if_id_hazard_ctrl.sv
// Directed bench for if_id_hazard_ctrl: a vector table for single-cycle behaviour
// plus hand-written timeout, reset and counter-saturation sequences.
module tb_if_id_hazard_ctrl;

    logic clk;
    logic rst_n;
    int   total_checks;
    int   passed_checks;

    if_id_hazard_ctrl_if #(.REG_W(5), .CNT_W(16)) bus ();

    if_id_hazard_ctrl #(.REG_W(5), .WAIT_W(4), .TIMEOUT(15), .CNT_W(16)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .hz    (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic [4:0]  rs, rt, ert;
        logic        mr, br, rdy;
        logic        pc, ifid, fl, bub, terr;
        logic [15:0] st, fc;
    } vec_t;

    vec_t vecs[$];

    task automatic checkOutput(input string name, input logic [15:0] act, input logic [15:0] exp);
        total_checks++;
        if (act === exp) passed_checks++;
        else $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
    endtask

    task automatic applyStimulus(input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] ert,
                                 input logic mr, input logic br, input logic rdy);
        bus.id_rs        = rs;
        bus.id_rt        = rt;
        bus.ex_rt        = ert;
        bus.ex_mem_read  = mr;
        bus.branch_taken = br;
        bus.imem_ready   = rdy;
    endtask

    // One cycle: drive at negedge, check Mealy outputs, clock, check counters.
    task automatic step(input vec_t v);
        applyStimulus(v.rs, v.rt, v.ert, v.mr, v.br, v.rdy);
        #1;
        checkOutput({v.name, ".pc_write"},     16'(bus.pc_write),     16'(v.pc));
        checkOutput({v.name, ".if_id_write"},  16'(bus.if_id_write),  16'(v.ifid));
        checkOutput({v.name, ".if_flush"},     16'(bus.if_flush),     16'(v.fl));
        checkOutput({v.name, ".id_ex_bubble"}, 16'(bus.id_ex_bubble), 16'(v.bub));
        checkOutput({v.name, ".timeout_err"},  16'(bus.timeout_err),  16'(v.terr));
        @(posedge clk);
        #1;
        checkOutput({v.name, ".stall_cnt"}, bus.stall_cnt, v.st);
        checkOutput({v.name, ".flush_cnt"}, bus.flush_cnt, v.fc);
        @(negedge clk);
    endtask

    function automatic vec_t mk(input string name, input logic [4:0] rs, input logic [4:0] rt,
                                input logic [4:0] ert, input logic mr, input logic br, input logic rdy,
                                input logic pc, input logic ifid, input logic fl, input logic bub,
                                input logic terr, input logic [15:0] st, input logic [15:0] fc);
        vec_t v;
        v.name = name; v.rs = rs; v.rt = rt; v.ert = ert;
        v.mr = mr; v.br = br; v.rdy = rdy;
        v.pc = pc; v.ifid = ifid; v.fl = fl; v.bub = bub; v.terr = terr;
        v.st = st; v.fc = fc;
        return v;
    endfunction

    task automatic do_reset();
        @(negedge clk);
        applyStimulus(5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1);
        rst_n = 1'b0;
        #1;
        checkOutput("rst.pc_write",     16'(bus.pc_write),     16'd0);
        checkOutput("rst.if_id_write",  16'(bus.if_id_write),  16'd0);
        checkOutput("rst.if_flush",     16'(bus.if_flush),     16'd0);
        checkOutput("rst.id_ex_bubble", 16'(bus.id_ex_bubble), 16'd1);
        checkOutput("rst.timeout_err",  16'(bus.timeout_err),  16'd0);
        checkOutput("rst.stall_cnt",    bus.stall_cnt,         16'd0);
        checkOutput("rst.flush_cnt",    bus.flush_cnt,         16'd0);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        #5_000_000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        total_checks  = 0;
        passed_checks = 0;
        rst_n = 1'b1;
        applyStimulus(5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1);

        //             name          rs rt ert mr br rdy  pc if fl bu te stall flush
        vecs.push_back(mk("load_use_rs", 5, 0, 5, 1, 0, 1,   0, 0, 0, 1, 0, 1, 0));
        vecs.push_back(mk("rt_zero",     0, 0, 0, 1, 0, 1,   1, 1, 0, 0, 0, 1, 0));
        vecs.push_back(mk("load_use_rt", 3, 7, 7, 1, 0, 1,   0, 0, 0, 1, 0, 2, 0));
        vecs.push_back(mk("no_load",     7, 7, 7, 0, 0, 1,   1, 1, 0, 0, 0, 2, 0));
        vecs.push_back(mk("br_over_lu",  5, 0, 5, 1, 1, 1,   1, 0, 1, 0, 0, 2, 1));
        vecs.push_back(mk("br_not_rdy",  1, 2, 0, 0, 1, 0,   1, 0, 1, 0, 0, 2, 2));
        vecs.push_back(mk("wait1",       1, 2, 0, 0, 0, 0,   0, 0, 0, 1, 0, 3, 2));
        vecs.push_back(mk("wait2_br",    1, 2, 0, 0, 1, 0,   0, 0, 0, 1, 0, 4, 2));
        vecs.push_back(mk("wait3",       1, 2, 0, 0, 0, 0,   0, 0, 0, 1, 0, 5, 2));
        vecs.push_back(mk("pend_exit",   5, 0, 5, 1, 1, 1,   1, 0, 1, 1, 0, 5, 3));
        vecs.push_back(mk("run_normal",  1, 2, 3, 0, 0, 1,   1, 1, 0, 0, 0, 5, 3));
        vecs.push_back(mk("imem_miss",   1, 2, 3, 0, 0, 0,   0, 0, 0, 1, 0, 6, 3));
        vecs.push_back(mk("wait_exit",   1, 2, 3, 0, 0, 1,   1, 1, 0, 0, 0, 6, 3));
        vecs.push_back(mk("lu_over_miss",4, 9, 9, 1, 0, 0,   0, 0, 0, 1, 0, 7, 3));
        vecs.push_back(mk("still_run_br",1, 2, 3, 0, 1, 1,   1, 0, 1, 0, 0, 7, 4));
        vecs.push_back(mk("run_after",   1, 2, 3, 0, 0, 1,   1, 1, 0, 0, 0, 7, 4));

        do_reset();
        foreach (vecs[i]) step(vecs[i]);

        // Fetch timeout: one RUN miss, fifteen WAIT cycles, then ERR is sticky.
        do_reset();
        step(mk("to_enter", 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 1, 0));
        for (int i = 0; i < 15; i++)
            step(mk("to_wait", 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 16'(2 + i), 0));
        for (int i = 0; i < 4; i++)
            step(mk("to_err", 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 16, 0));
        step(mk("err_rdy_br", 0, 0, 0, 0, 1, 1, 0, 0, 0, 1, 1, 16, 0));
        do_reset();
        step(mk("post_err", 0, 0, 0, 0, 0, 1, 1, 1, 0, 0, 0, 0, 0));

        // A reset during WAIT drops the pending flush.
        step(mk("pend_set", 0, 0, 0, 0, 1, 0, 1, 0, 1, 0, 0, 0, 1));
        do_reset();
        step(mk("pend_dropped", 0, 0, 0, 0, 0, 1, 1, 1, 0, 0, 0, 0, 0));

        // Stall counter saturation.
        do_reset();
        applyStimulus(5'd5, 5'd0, 5'd5, 1'b1, 1'b0, 1'b1);
        repeat (65534) @(posedge clk);
        #1;
        checkOutput("sat.stall_fffe", bus.stall_cnt, 16'hFFFE);
        repeat (3) @(posedge clk);
        #1;
        checkOutput("sat.stall_ffff", bus.stall_cnt, 16'hFFFF);
        checkOutput("sat.flush_zero", bus.flush_cnt, 16'h0000);

        $display("%0d/%0d checks passed", passed_checks, total_checks);
        $finish;
    end

endmodule
